// File: rtl/ps_rr_arbiter.sv
// ps_rr_arbiter: packet-level round-robin arbiter feeding one PacketStream output.
// A grant is held until the eop word of the granted requester is accepted.
// The output side is a two-entry buffer made of the output register and a skid
// register. It keeps o_rdy off every i_rdy path and every input off the o_* outputs.

module ps_rr_arbiter #(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 4,
    localparam int SELW  = $clog2(INPUTS)
) (
    input  logic                     reset_n,
    input  logic                     clk,
    input  logic [INPUTS*WIDTH-1:0]  i_dat,
    input  logic [INPUTS-1:0]        i_val,
    input  logic [INPUTS-1:0]        i_eop,
    output logic [INPUTS-1:0]        i_rdy,
    output logic [WIDTH-1:0]         o_dat,
    output logic                     o_val,
    output logic                     o_eop,
    input  logic                     o_rdy,
    output logic [SELW-1:0]          o_sel
);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_BUSY   = 1'b1;
    localparam logic [SELW-1:0] LAST_INIT = SELW'(INPUTS - 1);

    logic [0:0]        state_r;
    logic [SELW-1:0]   last_r;
    logic [SELW-1:0]   o_sel_r;
    logic [WIDTH-1:0]  o_dat_r;
    logic              o_val_r;
    logic              o_eop_r;
    logic [WIDTH-1:0]  skid_dat_r;
    logic              skid_eop_r;
    logic              skid_val_r;

    logic              grant_val_s;
    logic [SELW-1:0]   grant_idx_s;
    logic [WIDTH-1:0]  mux_dat_s;
    logic              mux_eop_s;
    logic              mux_val_s;
    logic              accept_s;
    logic              o_load_s;
    logic [INPUTS-1:0] i_rdy_s;

    // Requester index 'offs' positions after 'base', wrapping at INPUTS.
    function automatic logic [SELW-1:0] rr_index(input logic [SELW-1:0] base, input int offs);
        return SELW'((int'(base) + offs) % INPUTS);
    endfunction

    // Round-robin search: walk from the farthest candidate back to last+1 so the
    // nearest requesting index after the previous grant overwrites the others.
    always_comb begin
        grant_val_s = |i_val;
        grant_idx_s = {SELW{1'b0}};
        for (int i = INPUTS; i >= 1; i--) begin
            grant_idx_s = i_val[rr_index(last_r, i)] ? rr_index(last_r, i) : grant_idx_s;
        end
    end

    // AND-OR word mux on the granted requester and per-requester ready.
    // Ready depends only on registers, so o_rdy never reaches i_rdy.
    always_comb begin
        mux_dat_s = {WIDTH{1'b0}};
        mux_eop_s = 1'b0;
        mux_val_s = 1'b0;
        i_rdy_s   = {INPUTS{1'b0}};
        for (int k = 0; k < INPUTS; k++) begin
            mux_dat_s  = mux_dat_s | (i_dat[k*WIDTH +: WIDTH] & {WIDTH{o_sel_r == SELW'(k)}});
            mux_eop_s  = mux_eop_s | (i_eop[k] & (o_sel_r == SELW'(k)));
            mux_val_s  = mux_val_s | (i_val[k] & (o_sel_r == SELW'(k)));
            i_rdy_s[k] = (state_r == ST_BUSY) & (o_sel_r == SELW'(k)) & ~skid_val_r;
        end
    end

    // A word is accepted only in BUSY while the skid slot is free.
    // The output register may reload when it is empty or is being drained.
    always_comb begin
        accept_s = (state_r == ST_BUSY) & mux_val_s & ~skid_val_r;
        o_load_s = ~o_val_r | o_rdy;
    end

    // Grant FSM: take a grant in IDLE, and hold it until the eop word is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            last_r  <= LAST_INIT;
            o_sel_r <= {SELW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_val_s) begin
                        state_r <= ST_BUSY;
                        last_r  <= grant_idx_s;
                        o_sel_r <= grant_idx_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (accept_s && mux_eop_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register plus skid slot. The buffer drains regardless of FSM state,
    // and the skid slot catches a word accepted while the output is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_val_r    <= 1'b0;
            o_dat_r    <= {WIDTH{1'b0}};
            o_eop_r    <= 1'b0;
            skid_val_r <= 1'b0;
            skid_dat_r <= {WIDTH{1'b0}};
            skid_eop_r <= 1'b0;
        end else if (o_load_s) begin
            o_val_r    <= skid_val_r | accept_s;
            skid_val_r <= 1'b0;
            if (skid_val_r) begin
                o_dat_r <= skid_dat_r;
                o_eop_r <= skid_eop_r;
            end else if (accept_s) begin
                o_dat_r <= mux_dat_s;
                o_eop_r <= mux_eop_s;
            end else begin
                o_dat_r <= o_dat_r;
                o_eop_r <= o_eop_r;
            end
        end else if (accept_s) begin
            skid_val_r <= 1'b1;
            skid_dat_r <= mux_dat_s;
            skid_eop_r <= mux_eop_s;
        end else begin
            skid_val_r <= skid_val_r;
        end
    end

    assign i_rdy = i_rdy_s;
    assign o_dat = o_dat_r;
    assign o_val = o_val_r;
    assign o_eop = o_eop_r;
    assign o_sel = o_sel_r;

endmodule

// File: tb/tb_ps_rr_arbiter.sv
// Directed bench for ps_rr_arbiter, with a randomized stress phase at the end.
// Every source k sends words {k[1:0], seq[5:0]} and packets of a configured length.
// Expected values come from hand-traced cycle tables or from the source configuration.

module tb_ps_rr_arbiter;

    localparam int WIDTH  = 8;
    localparam int INPUTS = 4;
    localparam int SELW   = 2;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [INPUTS*WIDTH-1:0] i_dat;
    logic [INPUTS-1:0]       i_val;
    logic [INPUTS-1:0]       i_eop;
    logic [INPUTS-1:0]       i_rdy;
    logic [WIDTH-1:0]        o_dat;
    logic                    o_val;
    logic                    o_eop;
    logic                    o_rdy;
    logic [SELW-1:0]         o_sel;

    ps_rr_arbiter #(.WIDTH(WIDTH), .INPUTS(INPUTS)) dut (
        .reset_n(reset_n), .clk(clk),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
        .o_sel(o_sel)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // source model
    int         src_len  [INPUTS];
    int         src_left [INPUTS];
    int         src_pos  [INPUTS];
    int         src_prob [INPUTS];
    int         src_sent [INPUTS];
    logic [5:0] src_seq  [INPUTS];

    // sink record and stream checker state
    logic [8:0] sq[$];
    int         sc[$];
    int         cyc = 0;
    bit         stress = 1'b0;
    int         rcv     [INPUTS];
    int         exp_pos [INPUTS];
    logic [5:0] exp_seq [INPUTS];
    bit         in_pkt = 1'b0;
    int         cur_src = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_src(input int k, input int len, input int npkt, input int prob);
        src_len[k]  = len;
        src_left[k] = npkt;
        src_pos[k]  = 0;
        src_prob[k] = prob;
        src_sent[k] = 0;
        src_seq[k]  = 6'd0;
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < INPUTS; k++) begin
            i_val[k] = (src_left[k] > 0) && ($urandom_range(0, 99) < src_prob[k]);
            i_dat[k*WIDTH +: WIDTH] = {2'(k), src_seq[k]};
            i_eop[k] = (src_pos[k] == src_len[k] - 1);
        end
    endtask

    task automatic sink_chk(input logic [8:0] w);
        int s;
        s = int'(w[7:6]);
        if (in_pkt) check("t6_interleave", 32'(s), 32'(cur_src));
        check("t6_seq", 32'(w[5:0]), 32'(exp_seq[s]));
        check("t6_eop", 32'(w[8]), 32'(exp_pos[s] == src_len[s] - 1));
        exp_seq[s] = exp_seq[s] + 6'd1;
        exp_pos[s] = (exp_pos[s] == src_len[s] - 1) ? 0 : exp_pos[s] + 1;
        in_pkt  = !w[8];
        cur_src = s;
        rcv[s]++;
    endtask

    // Capture handshakes at the negedge, then update the models just after the posedge.
    task automatic tick();
        logic [INPUTS-1:0] f;
        bit                of;
        logic [8:0]        ow;
        @(negedge clk);
        f  = i_val & i_rdy;
        of = o_val & o_rdy;
        ow = {o_eop, o_dat};
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < INPUTS; k++) begin
            if (f[k]) begin
                src_sent[k]++;
                src_seq[k] = src_seq[k] + 6'd1;
                if (src_pos[k] == src_len[k] - 1) begin
                    src_pos[k] = 0;
                    src_left[k]--;
                end else begin
                    src_pos[k]++;
                end
            end
        end
        if (of) begin
            sq.push_back(ow);
            sc.push_back(cyc);
            if (stress) sink_chk(ow);
        end
        drive_srcs();
    endtask

    task automatic drain();
        int n = 0;
        o_rdy = 1'b1;
        while (o_val === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("drain", 32'(o_val), 32'h0);
        tick();
    endtask

    task automatic wait_words(input int n, input int bound);
        int i = 0;
        while (sq.size() < n && i < bound) begin
            tick();
            i++;
        end
        check("word_count", 32'(sq.size()), 32'(n));
    endtask

    bit [0:12] rdy_tab  = 13'b1001100110011;
    bit [0:12] irdy_tab = 13'b0110110010000;
    bit [0:12] oval_tab = 13'b0011111111110;

    initial begin
        int left_total;
        for (int k = 0; k < INPUTS; k++) set_src(k, 1, 0, 0);

        // 1: reset with random inputs
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_val = 4'($urandom);
            i_dat = 32'($urandom);
            i_eop = 4'($urandom);
            o_rdy = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst_o_val", 32'(o_val), 32'h0);
        check("rst_o_eop", 32'(o_eop), 32'h0);
        check("rst_o_dat", 32'(o_dat), 32'h0);
        check("rst_i_rdy", 32'(i_rdy), 32'h0);
        check("rst_o_sel", 32'(o_sel), 32'h0);

        // 2: all four send two 3-word packets, o_rdy held high
        for (int k = 0; k < INPUTS; k++) set_src(k, 3, 2, 100);
        o_rdy = 1'b1;
        drive_srcs();
        sq.delete();
        sc.delete();
        reset_n = 1'b1;
        tick();
        check("t1_first_sel", 32'(o_sel), 32'h0);
        check("t1_first_rdy", 32'(i_rdy), 32'h1);
        wait_words(24, 300);
        for (int i = 0; i < 24 && i < sq.size(); i++) begin
            int p, k, w;
            logic [8:0] e;
            p = i / 12;
            k = (i % 12) / 3;
            w = i % 3;
            e = {w == 2, 2'(k), 6'(p * 3 + w)};
            check("t2_word", 32'(sq[i]), 32'(e));
            if (i > 0) check("t2_gap", 32'(sc[i] - sc[i-1]), (w == 0) ? 32'd2 : 32'd1);
        end

        // 3: requester 2 alone, 5-word packet, o_rdy pattern 1,0,0,1
        drain();
        sq.delete();
        set_src(2, 5, 1, 100);
        drive_srcs();
        for (int c = 0; c < 13; c++) begin
            o_rdy = rdy_tab[c];
            check("t3_irdy2", 32'(i_rdy[2]), 32'(irdy_tab[c]));
            check("t3_oval", 32'(o_val), 32'(oval_tab[c]));
            tick();
        end
        check("t3_words", 32'(sq.size()), 32'd5);
        for (int i = 0; i < 5 && i < sq.size(); i++) begin
            logic [8:0] e;
            e = {i == 4, 2'd2, 6'(i)};
            check("t3_word", 32'(sq[i]), 32'(e));
        end

        // 4: requester 1 sends a single-word packet, requester 3 joins after that grant
        drain();
        sq.delete();
        set_src(1, 1, 1, 100);
        drive_srcs();
        check("t4_c0_rdy", 32'(i_rdy), 32'h0);
        tick();
        check("t4_c1_sel", 32'(o_sel), 32'd1);
        check("t4_c1_rdy", 32'(i_rdy), 32'b0010);
        set_src(3, 2, 1, 100);
        drive_srcs();
        tick();
        check("t4_c2_sel", 32'(o_sel), 32'd1);
        check("t4_c2_val", 32'(o_val), 32'h1);
        check("t4_c2_dat", 32'(o_dat), 32'h40);
        check("t4_c2_eop", 32'(o_eop), 32'h1);
        check("t4_c2_rdy", 32'(i_rdy), 32'h0);
        tick();
        check("t4_c3_sel", 32'(o_sel), 32'd3);
        check("t4_c3_rdy", 32'(i_rdy), 32'b1000);
        check("t4_c3_val", 32'(o_val), 32'h0);
        tick();
        check("t4_c4_val", 32'(o_val), 32'h1);
        check("t4_c4_dat", 32'(o_dat), 32'hC0);
        check("t4_c4_eop", 32'(o_eop), 32'h0);
        tick();
        check("t4_c5_dat", 32'(o_dat), 32'hC1);
        check("t4_c5_eop", 32'(o_eop), 32'h1);

        // 5: reset in the middle of a packet from requester 0
        drain();
        set_src(0, 6, 1, 100);
        drive_srcs();
        tick();
        tick();
        tick();
        check("t5_pre_val", 32'(o_val), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_val", 32'(o_val), 32'h0);
        check("t5_rst_rdy", 32'(i_rdy), 32'h0);
        check("t5_rst_sel", 32'(o_sel), 32'h0);
        sq.delete();
        for (int k = 0; k < INPUTS; k++) set_src(k, 1, 1, 100);
        drive_srcs();
        tick();
        reset_n = 1'b1;
        tick();
        check("t5_sel", 32'(o_sel), 32'h0);
        check("t5_rdy", 32'(i_rdy), 32'b0001);
        wait_words(4, 50);
        for (int i = 0; i < 4 && i < sq.size(); i++) begin
            logic [8:0] e;
            e = {1'b1, 2'(i), 6'd0};
            check("t5_word", 32'(sq[i]), 32'(e));
        end

        // 6: random valid and ready; stream checker verifies order, eop and completeness
        drain();
        sq.delete();
        stress = 1'b1;
        in_pkt = 1'b0;
        for (int k = 0; k < INPUTS; k++) begin
            set_src(k, k + 1, 150, 60);
            rcv[k]     = 0;
            exp_pos[k] = 0;
            exp_seq[k] = 6'd0;
        end
        drive_srcs();
        for (int i = 0; i < 10000; i++) begin
            o_rdy = ($urandom_range(0, 99) < 70);
            tick();
        end
        o_rdy = 1'b1;
        left_total = 0;
        for (int k = 0; k < INPUTS; k++) left_total += src_left[k];
        for (int n = 0; n < 3000 && (left_total > 0 || o_val === 1'b1); n++) begin
            tick();
            left_total = 0;
            for (int k = 0; k < INPUTS; k++) left_total += src_left[k];
        end
        check("t6_done", 32'(left_total), 32'h0);
        check("t6_tail", 32'(in_pkt), 32'h0);
        for (int k = 0; k < INPUTS; k++) begin
            check("t6_sent", 32'(src_sent[k]), 32'(150 * (k + 1)));
            check("t6_rcv", 32'(rcv[k]), 32'(150 * (k + 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
